toggle_rx: RTL
==============

# toggle_rx

Receiving end of the two-phase toggle event link driven by the toggle register block (one output flip per event, `toggle_en` pulse in the source domain). `toggle_rx` sits in the destination clock domain, e.g. the system clock receiving VGA-domain frame and line events. It synchronizes the incoming level and converts every level change back into a one-cycle pulse. Events are queued in a pending counter behind a valid/ready consumer handshake, and each accepted event is acknowledged to the sender with a return toggle.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flops on `i_toggle`; legal range 2..4.
- `PEND_W`, default 4: pending-event counter width; holds up to 2^PEND_W-1 events.
- `CNT_W`, default 16: free-running event counter width.

Ports:
- `clk`  in  1  destination-domain clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `i_toggle`  in  1  asynchronous toggle level from the sender domain.
- `i_evt_ready`  in  1  consumer accepts one event this cycle.
- `i_clr`  in  1  synchronous clear of the pending count, the event count and the overflow flag.
- `o_pulse`  out  1  one-cycle pulse per detected toggle.
- `o_evt_valid`  out  1  at least one event is pending.
- `o_pending`  out  PEND_W  current pending count.
- `o_ack_toggle`  out  1  flips once per accepted event; routed back to the sender domain.
- `o_evt_count`  out  CNT_W  total detected events, modulo 2^CNT_W.
- `o_overflow`  out  1  sticky; an event was lost because pending was full.

## Operation
- Reset values:
  - synchronizer chain = 0, `r_last` = 0, state = ARM.
  - `o_pulse` = 0, `o_evt_valid` = 0, `o_pending` = 0.
  - `o_ack_toggle` = 0, `o_evt_count` = 0, `o_overflow` = 0.
- FSM with two states:
  - ARM: lasts SYNC_STAGES+1 cycles after reset release. `r_last` loads the synchronizer output every cycle and no pulses are generated. This suppresses a spurious event when the sender is already at level 1. At the end of the window the FSM moves to RUN.
  - RUN: `edge` = sync_out XOR `r_last`; `r_last` <= sync_out. RUN exits only on reset.
- `o_pulse` is registered from `edge` and is high for exactly one cycle per level change.
- Accept = `o_evt_valid` AND `i_evt_ready`. `o_evt_valid` is driven combinationally from the registered pending count (pending != 0).
- Pending update per cycle:
  - pulse only: +1.
  - accept only: -1.
  - pulse and accept: unchanged.
  - pulse with pending = max and no accept: pending stays at max and `o_overflow` is set.
- `i_evt_ready` while pending = 0 has no effect.
- `o_ack_toggle` inverts on every accept.
- `o_evt_count` increments on every pulse, including pulses that overflow; it wraps from all-ones to 0.
- `i_clr` has priority:
  - pending, count and overflow clear to 0.
  - A pulse in the same cycle is then applied, giving pending = 1 and count = 1.
  - An accept in the same cycle still flips `o_ack_toggle`.
- `i_clr` during ARM is honoured and does not change the ARM timing.

## Timing
- Latency from an `i_toggle` change to `o_pulse` high: SYNC_STAGES+1 clk edges (3 with the default).
- `o_pulse` to `o_evt_valid`: same edge, because pending updates together with the pulse register.
- Accept to `o_ack_toggle` change: 1 cycle.
- Input constraint: the sender must not toggle again within SYNC_STAGES+1 destination cycles, otherwise two changes can merge into no edge. This limit is a documented rule and is not detected in hardware.
- Reset asserted mid-operation clears everything immediately, with no clock required. Pending events are discarded and the block re-enters ARM.

## Structure
- Shared package `toggle_pkg`:
  - `SYNC_STAGES_MIN` = 2 and `SYNC_STAGES_DEF` = 2.
  - FSM state enum {ARM, RUN}.
- Sub-module `sync_bit`: an N-stage synchronizer with asynchronous active-low reset to 0, reusable on the sender side for `o_ack_toggle`.
- The ARM counter width is clog2(SYNC_STAGES+2).

## Test plan
- Hold `i_toggle` = 1 through reset and release -> no `o_pulse`, count 0 after ARM; a later fall to 0 -> one pulse, count 1.
- Three toggles spaced 5 cycles apart, `i_evt_ready` = 0 -> three pulses, each 3 cycles after its toggle; pending 3; valid 1; ack unchanged.
- Then assert `i_evt_ready` for 4 cycles -> pending 3→2→1→0, ack flips 3 times, valid drops on the cycle pending reaches 0, and the 4th ready cycle has no effect.
- PEND_W = 2, 4 toggles with no ready -> pending saturates at 3, overflow = 1, count = 4; `i_clr` -> all 0.
- Pulse coinciding with accept at pending 2 -> pending stays 2, ack flips; pulse coinciding with `i_clr` -> pending 1, count 1.
- CNT_W = 4, 17 toggles with ready held at 1 -> count wraps to 1, pending 0, overflow 0; `rstn` pulsed mid-sequence -> outputs 0 asynchronously and the block re-arms.

Source files
------------

// File: rtl/toggle_pkg.sv
// Shared definitions for the two-phase toggle event link.
package toggle_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [0:0] {
    ARM,
    RUN
  } rx_state_e;

endpackage

// File: rtl/toggle_rx_if.sv
// Consumer-side handshake of the toggle receiver: pending events offered with valid/ready,
// plus the return acknowledge toggle routed back to the sender domain.
interface toggle_rx_if #(
  parameter int unsigned PEND_W = 4
);

  logic              i_evt_ready;
  logic              o_evt_valid;
  logic [PEND_W-1:0] o_pending;
  logic              o_ack_toggle;

  modport master (
    input  i_evt_ready,
    output o_evt_valid,
    output o_pending,
    output o_ack_toggle
  );

  modport slave (
    output i_evt_ready,
    input  o_evt_valid,
    input  o_pending,
    input  o_ack_toggle
  );

endinterface

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer with asynchronous active-low reset to 0.
// Also used on the sender side to bring the acknowledge toggle back.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/toggle_rx.sv
// Destination-domain receiver of the two-phase toggle link: turns each level change into a
// one-cycle pulse, queues events behind valid/ready and returns an acknowledge toggle.
module toggle_rx
  import toggle_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned PEND_W      = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_toggle,
  input  logic             i_clr,
  toggle_rx_if.master      evt,
  output logic             o_pulse,
  output logic [CNT_W-1:0] o_evt_count,
  output logic             o_overflow
);

  localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("toggle_rx: SYNC_STAGES out of range");
  end

  rx_state_e         state_q, state_d;
  logic [ARM_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic              sync_out;
  logic              last_q;
  logic              evt_edge;
  logic              pulse_q;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              ack_q, ack_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              accept;
  logic              full;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (i_toggle),
    .q   (sync_out)
  );

  // ARM absorbs whatever level the sender holds at reset release, so no edge is reported for it.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    evt_edge  = 1'b0;
    unique case (state_q)
      ARM: begin
        arm_cnt_d = arm_cnt_q + ARM_W'(1);
        if (arm_cnt_q == ARM_LAST) begin
          state_d = RUN;
        end
      end
      RUN:     evt_edge = sync_out ^ last_q;
      default: state_d = ARM;
    endcase
  end

  assign accept = evt.o_evt_valid & evt.i_evt_ready;
  assign full   = &pending_q;

  // Clear wins over the stored values, but a pulse in the same cycle still lands afterwards.
  always_comb begin
    pending_d = pending_q;
    count_d   = count_q + CNT_W'(evt_edge);
    ovf_d     = ovf_q;
    ack_d     = ack_q ^ accept;
    if (i_clr) begin
      pending_d = PEND_W'(evt_edge);
      count_d   = CNT_W'(evt_edge);
      ovf_d     = 1'b0;
    end else if (evt_edge && !accept) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        pending_d = pending_q + PEND_W'(1);
      end
    end else if (!evt_edge && accept) begin
      pending_d = pending_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ARM;
      arm_cnt_q <= '0;
      last_q    <= 1'b0;
      pulse_q   <= 1'b0;
      pending_q <= '0;
      ack_q     <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      last_q    <= sync_out;
      pulse_q   <= evt_edge;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_pulse          = pulse_q;
  assign o_evt_count      = count_q;
  assign o_overflow       = ovf_q;
  assign evt.o_evt_valid  = (pending_q != '0);
  assign evt.o_pending    = pending_q;
  assign evt.o_ack_toggle = ack_q;

endmodule
